// File: rtl/dispatch_issue_pkg.sv
// Shared types for the dispatch-to-issue path: functional-unit classes,
// the decoded instruction record and the issue-stage FSM states.
package dispatch_issue_pkg;

    localparam int NUM_RS_DEF    = 3;
    localparam int ROB_DEPTH_DEF = 32;

    // Functional-unit class; encodings above FU_BR are legal on the wire
    // and are steered to the ALU station by the issue stage.
    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MEM = 2'd1,
        FU_BR  = 2'd2
    } fu_type_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        fu_type_e    fu_type;
    } decoded_instr_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } stage_state_e;

endpackage

// File: rtl/dispatch_issue.sv
// Consumer end of the dispatch queue: pops the head, allocates a ROB tag and
// presents the instruction to its reservation station from a one-entry
// registered issue stage.
module dispatch_issue
    import dispatch_issue_pkg::*;
#(
    parameter  int NUM_RS    = NUM_RS_DEF,
    parameter  int ROB_DEPTH = ROB_DEPTH_DEF,
    localparam int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 q_empty,
    input  decoded_instr_t       q_instr,
    output logic                 q_r_en,
    input  logic                 rob_free,
    output logic                 rob_alloc,
    output logic [TAG_W-1:0]     rob_tag,
    input  logic                 flush,
    input  logic [NUM_RS-1:0]    rs_ready,
    output logic [NUM_RS-1:0]    rs_valid,
    output decoded_instr_t       rs_instr,
    output logic [TAG_W-1:0]     rs_tag,
    output logic [31:0]          stall_cnt
);

    stage_state_e     state_q, state_d;
    decoded_instr_t   instr_q, instr_d;
    logic [TAG_W-1:0] rs_tag_q, rs_tag_d;
    logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;
    logic [NUM_RS-1:0] sel_q, sel_d;
    logic [NUM_RS-1:0] tgt_oh;
    logic [31:0]      stall_cnt_q, stall_cnt_d;
    logic             pop;
    logic             cons;
    logic             held_blocked;

    // Decode the queue head's unit class into a one-hot RS select; unknown
    // classes fall back to RS 0.
    always_comb begin
        tgt_oh = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (int'(q_instr.fu_type) == i) tgt_oh[i] = 1'b1;
        end
        if (tgt_oh == '0) tgt_oh[0] = 1'b1;
    end

    // FSM outputs: handshake toward the queue/ROB and the RS offer.
    always_comb begin
        cons         = (state_q == ST_HOLD) && |(sel_q & rs_ready);
        held_blocked = (state_q == ST_HOLD) && !(|(sel_q & rs_ready));
        // Gating with rst_n keeps the queue untouched while reset is held.
        pop          = rst_n && !q_empty && rob_free && !flush &&
                       ((state_q == ST_IDLE) || cons);
        rs_valid     = (state_q == ST_HOLD) ? sel_q : '0;
    end

    assign q_r_en    = pop;
    assign rob_alloc = pop;
    assign rob_tag   = tag_cnt_q;
    assign rs_instr  = instr_q;
    assign rs_tag    = rs_tag_q;
    assign stall_cnt = stall_cnt_q;

    // FSM next state: flush wins, a pop refills the stage, a bare consume empties it.
    always_comb begin
        state_d = state_q;
        if (flush)     state_d = ST_IDLE;
        else if (pop)  state_d = ST_HOLD;
        else if (cons) state_d = ST_IDLE;
    end

    // Datapath next values: stage capture, tag allocation, stall accounting.
    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        instr_d     = instr_q;
        rs_tag_d    = rs_tag_q;
        sel_d       = sel_q;
        tag_cnt_d   = tag_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (pop) begin
            instr_d   = q_instr;
            rs_tag_d  = tag_cnt_q;
            sel_d     = tgt_oh;
            tag_cnt_d = (tag_cnt_q == TAG_W'(ROB_DEPTH - 1)) ? '0 : tag_cnt_q + 1'b1;
        end
        if (flush) tag_cnt_d = '0;
        if (held_blocked && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q       <= '0;
            tag_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            sel_q       <= sel_d;
            tag_cnt_q   <= tag_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Stage payload register.
    always_ff @(posedge clk) begin
        // NOTE: payload is not reset; it is only observed while the stage is HOLD.
        instr_q  <= instr_d;
        rs_tag_q <= rs_tag_d;
    end

endmodule

// File: tb/tb_dispatch_issue.sv
// Directed bench for dispatch_issue: reset, single issue, back-to-back issue,
// RS backpressure, ROB-full, tag wrap and flush.
module tb_dispatch_issue;
    import dispatch_issue_pkg::*;

    localparam int TAG_W = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 q_empty;
    decoded_instr_t       q_instr;
    logic                 q_r_en;
    logic                 rob_free;
    logic                 rob_alloc;
    logic [TAG_W-1:0]     rob_tag;
    logic                 flush;
    logic [2:0]           rs_ready;
    logic [2:0]           rs_valid;
    decoded_instr_t       rs_instr;
    logic [TAG_W-1:0]     rs_tag;
    logic [31:0]          stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dispatch_issue #(.NUM_RS(3), .ROB_DEPTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .q_empty   (q_empty),
        .q_instr   (q_instr),
        .q_r_en    (q_r_en),
        .rob_free  (rob_free),
        .rob_alloc (rob_alloc),
        .rob_tag   (rob_tag),
        .flush     (flush),
        .rs_ready  (rs_ready),
        .rs_valid  (rs_valid),
        .rs_instr  (rs_instr),
        .rs_tag    (rs_tag),
        .stall_cnt (stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic decoded_instr_t mk(input logic [1:0] fu, input logic [6:0] op);
        decoded_instr_t d;
        d.opcode  = op;
        d.rd      = op[4:0];
        d.rs1     = 5'd1;
        d.rs2     = 5'd2;
        d.imm     = {25'h0, op};
        d.fu_type = fu_type_e'(fu);
        return d;
    endfunction

    logic [1:0] t3_fu [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
    logic [2:0] t3_oh [4] = '{3'b010, 3'b100, 3'b001, 3'b010};
    logic [2:0] wr_oh [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        decoded_instr_t mem_i;

        // 1: reset held for two cycles with a non-empty queue
        rst_n = 1'b0; q_empty = 1'b0; q_instr = mk(2'd0, 7'h01);
        rob_free = 1'b1; flush = 1'b0; rs_ready = 3'b111;
        #1;
        check("rst_q_r_en0", q_r_en, 0);
        check("rst_alloc0", rob_alloc, 0);
        cyc();
        check("rst_q_r_en1", q_r_en, 0);
        cyc();
        check("rst_q_r_en2", q_r_en, 0);
        check("rst_rs_valid", rs_valid, 0);
        check("rst_stall", stall_cnt, 0);
        q_empty = 1'b1; rst_n = 1'b1;
        #1;
        check("rst_tag", rob_tag, 0);

        // 2: single ALU instruction
        q_empty = 1'b0; q_instr = mk(2'd0, 7'h11);
        #1;
        check("t2_pop", q_r_en, 1);
        check("t2_alloc", rob_alloc, 1);
        check("t2_rob_tag", rob_tag, 0);
        cyc();
        q_empty = 1'b1;
        #1;
        check("t2_rs_valid", rs_valid, 3'b001);
        check("t2_rs_tag", rs_tag, 0);
        check("t2_rs_instr", rs_instr, mk(2'd0, 7'h11));
        check("t2_no_pop", q_r_en, 0);
        cyc();
        check("t2_idle", rs_valid, 0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
        check("t2_flush_tag", rob_tag, 0);

        // 3: four back-to-back issues
        for (int k = 0; k < 4; k++) begin
            q_empty = 1'b0; q_instr = mk(t3_fu[k], 7'(7'h20 + k));
            #1;
            check("t3_pop", q_r_en, 1);
            check("t3_rob_tag", rob_tag, k);
            if (k > 0) begin
                check("t3_rs_valid", rs_valid, t3_oh[k-1]);
                check("t3_rs_tag", rs_tag, k - 1);
            end
            cyc();
        end
        q_empty = 1'b1;
        #1;
        check("t3_last_valid", rs_valid, 3'b010);
        check("t3_last_tag", rs_tag, 3);
        cyc();
        check("t3_idle", rs_valid, 0);

        // 4: MEM instruction stalled for 5 cycles
        mem_i = mk(2'd1, 7'h44);
        q_empty = 1'b0; q_instr = mem_i; rs_ready = 3'b101;
        #1;
        check("t4_pop", q_r_en, 1);
        check("t4_rob_tag", rob_tag, 4);
        cyc();
        q_instr = mk(2'd0, 7'h45);
        for (int j = 0; j < 5; j++) begin
            #1;
            check("t4_stall_no_pop", q_r_en, 0);
            check("t4_stall_valid", rs_valid, 3'b010);
            check("t4_stall_instr", rs_instr, mem_i);
            cyc();
        end
        check("t4_stall_cnt", stall_cnt, 5);
        rs_ready = 3'b111;
        #1;
        check("t4_cons_pop", q_r_en, 1);
        check("t4_cons_valid", rs_valid, 3'b010);
        check("t4_cons_tag", rs_tag, 4);
        check("t4_next_tag", rob_tag, 5);
        cyc();
        q_empty = 1'b1;
        #1;
        check("t4_next_valid", rs_valid, 3'b001);
        check("t4_next_rs_tag", rs_tag, 5);
        check("t4_stall_hold", stall_cnt, 5);
        cyc();
        check("t4_idle", rs_valid, 0);

        // 5: ROB full blocks pops, held instruction still drains
        q_empty = 1'b0; q_instr = mk(2'd2, 7'h50);
        #1;
        check("t5_pop", q_r_en, 1);
        check("t5_rob_tag", rob_tag, 6);
        cyc();
        rob_free = 1'b0; q_instr = mk(2'd0, 7'h51);
        #1;
        check("t5_full_no_pop", q_r_en, 0);
        check("t5_full_no_alloc", rob_alloc, 0);
        check("t5_drain_valid", rs_valid, 3'b100);
        cyc();
        check("t5_drained", rs_valid, 0);
        check("t5_still_no_pop", q_r_en, 0);
        check("t5_tag_kept", rob_tag, 7);
        rob_free = 1'b1; q_instr = mk(2'd1, 7'h52);
        #1;
        check("t5_resume_pop", q_r_en, 1);
        check("t5_resume_tag", rob_tag, 7);
        cyc();

        // flush while holding: not delivered, tags restart at 0
        rs_ready = 3'b000; flush = 1'b1; q_instr = mk(2'd0, 7'h53);
        #1;
        check("t5_flush_no_pop", q_r_en, 0);
        check("t5_flush_valid", rs_valid, 3'b010);
        cyc();
        flush = 1'b0; rs_ready = 3'b111; q_empty = 1'b1;
        #1;
        check("t5_post_flush_valid", rs_valid, 0);
        check("t5_post_flush_tag", rob_tag, 0);
        check("t5_stall_cnt", stall_cnt, 6);

        // 6: 33 issues wrap the tag; class 3 routes to RS 0
        for (int i = 0; i < 33; i++) begin
            q_empty = 1'b0; q_instr = mk(2'(i % 4), 7'(i));
            #1;
            check("t6_pop", q_r_en, 1);
            check("t6_rob_tag", rob_tag, i % 32);
            if (i > 0) begin
                check("t6_rs_valid", rs_valid, wr_oh[(i-1) % 4]);
                check("t6_rs_tag", rs_tag, (i - 1) % 32);
            end
            cyc();
        end
        rs_ready = 3'b000; flush = 1'b1; q_instr = mk(2'd2, 7'h60);
        #1;
        check("t6_flush_no_pop", q_r_en, 0);
        check("t6_wrap_valid", rs_valid, 3'b001);
        check("t6_wrap_tag", rs_tag, 0);
        cyc();
        flush = 1'b0; rs_ready = 3'b111;
        #1;
        check("t6_flush_valid", rs_valid, 0);
        check("t6_flush_tag", rob_tag, 0);
        check("t6_flush_pop", q_r_en, 1);
        check("t6_stall_cnt", stall_cnt, 7);
        cyc();
        q_empty = 1'b1;
        #1;
        check("t6_after_valid", rs_valid, 3'b100);
        check("t6_after_tag", rs_tag, 0);
        cyc();
        check("t6_final_idle", rs_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
